// File: rtl/modexp_controller_pkg.sv
// Shared types and defaults for the modular exponentiation controller.
// Holds the FSM state encoding and default operand widths.
package modexp_controller_pkg;

  localparam int DEF_DATA_W = 512;
  localparam int DEF_EXP_W  = 512;

  typedef enum logic [2:0] {
    IDLE,
    TOMONT,
    SQUARE,
    MULT,
    FROMMONT,
    FINISH
  } state_t;

endpackage

// File: rtl/modexp_controller_montgomery.sv
// Bit-serial radix-2 Montgomery multiplier: result = a*b*2^-DATA_W mod m.
// Requires a, b < m and odd m; one operand bit per cycle, then a final reduction.
module montgomery
  import modexp_controller_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic [DATA_W-1:0] in_m,
  output logic [DATA_W-1:0] result,
  output logic              done
);

  localparam int CW = $clog2(DATA_W + 1);

  logic              r_run;
  logic [CW-1:0]     r_cnt;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic [DATA_W-1:0] r_m;
  logic [DATA_W+1:0] r_acc;

  logic [DATA_W+1:0] w_s1;
  logic [DATA_W+1:0] w_s2;
  logic [DATA_W-1:0] w_sub;

  // Accumulator stays below 2m, so the sum below stays below 4m.
  assign w_s1  = r_acc + (r_a[0] ? {2'b00, r_b} : '0);
  assign w_s2  = w_s1 + (w_s1[0] ? {2'b00, r_m} : '0);
  assign w_sub = r_acc[DATA_W-1:0] - r_m;

  // Iterate over the bits of a, then emit the reduced result with done.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_run  <= 1'b0;
      r_cnt  <= '0;
      r_a    <= '0;
      r_b    <= '0;
      r_m    <= '0;
      r_acc  <= '0;
      result <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start && !r_run) begin
        r_run <= 1'b1;
        r_cnt <= '0;
        r_a   <= in_a;
        r_b   <= in_b;
        r_m   <= in_m;
        r_acc <= '0;
      end else if (r_run) begin
        if (r_cnt == CW'(DATA_W)) begin
          r_run <= 1'b0;
          done  <= 1'b1;
          if (r_acc >= {2'b00, r_m})
            result <= w_sub;
          else
            result <= r_acc[DATA_W-1:0];
        end else begin
          r_acc <= w_s2 >> 1;
          r_a   <= r_a >> 1;
          r_cnt <= r_cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/modexp_controller.sv
// Left-to-right square-and-multiply modular exponentiation controller.
// Sequences one Montgomery multiplier through to/from Montgomery form.
module modexp_controller
  import modexp_controller_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int EXP_W  = DEF_EXP_W
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   start,
  input  logic [DATA_W-1:0]      in_x,
  input  logic [EXP_W-1:0]       in_e,
  input  logic [$clog2(EXP_W):0] in_t,
  input  logic [DATA_W-1:0]      in_m,
  input  logic [DATA_W-1:0]      in_r,
  input  logic [DATA_W-1:0]      in_r2,
  output logic [DATA_W-1:0]      result,
  output logic                   done,
  output logic                   busy
);

  localparam int TW = $clog2(EXP_W) + 1;
  localparam int IW = $clog2(EXP_W);

  state_t            r_state;
  logic [IW-1:0]     r_i;
  logic [EXP_W-1:0]  r_e;
  logic [TW-1:0]     r_t;
  logic [DATA_W-1:0] r_r;
  logic [DATA_W-1:0] r_xt;
  logic [DATA_W-1:0] r_result;
  logic              r_done;
  logic              r_busy;
  logic              r_mm_start;
  logic [DATA_W-1:0] r_mm_a;
  logic [DATA_W-1:0] r_mm_b;
  logic [DATA_W-1:0] r_mm_m;

  logic [DATA_W-1:0] w_mm_res;
  logic              w_mm_done;

  assign result = r_result;
  assign done   = r_done;
  assign busy   = r_busy;

  montgomery #(
    .DATA_W(DATA_W)
  ) u_mm (
    .clk   (clk),
    .resetn(resetn),
    .start (r_mm_start),
    .in_a  (r_mm_a),
    .in_b  (r_mm_b),
    .in_m  (r_mm_m),
    .result(w_mm_res),
    .done  (w_mm_done)
  );

  // Main FSM; each transition into a compute state issues the next multiply.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state    <= IDLE;
      r_i        <= '0;
      r_e        <= '0;
      r_t        <= '0;
      r_r        <= '0;
      r_xt       <= '0;
      r_result   <= '0;
      r_done     <= 1'b0;
      r_busy     <= 1'b0;
      r_mm_start <= 1'b0;
      r_mm_a     <= '0;
      r_mm_b     <= '0;
      r_mm_m     <= '0;
    end else begin
      r_mm_start <= 1'b0;
      r_done     <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_e        <= in_e;
            r_t        <= in_t;
            r_r        <= in_r;
            r_mm_a     <= in_x;
            r_mm_b     <= in_r2;
            r_mm_m     <= in_m;
            r_mm_start <= 1'b1;
            r_busy     <= 1'b1;
            r_state    <= TOMONT;
          end
        end
        TOMONT: begin
          if (w_mm_done) begin
            r_xt       <= w_mm_res;
            r_mm_a     <= r_r;
            r_mm_start <= 1'b1;
            if (r_t != '0) begin
              r_i     <= IW'(r_t - TW'(1));
              r_mm_b  <= r_r;
              r_state <= SQUARE;
            end else begin
              r_mm_b  <= DATA_W'(1);
              r_state <= FROMMONT;
            end
          end
        end
        SQUARE: begin
          if (w_mm_done) begin
            r_mm_a     <= w_mm_res;
            r_mm_start <= 1'b1;
            if (r_e[r_i]) begin
              r_mm_b  <= r_xt;
              r_state <= MULT;
            end else if (r_i != '0) begin
              r_i    <= r_i - IW'(1);
              r_mm_b <= w_mm_res;
            end else begin
              r_mm_b  <= DATA_W'(1);
              r_state <= FROMMONT;
            end
          end
        end
        MULT: begin
          if (w_mm_done) begin
            r_mm_a     <= w_mm_res;
            r_mm_start <= 1'b1;
            if (r_i != '0) begin
              r_i     <= r_i - IW'(1);
              r_mm_b  <= w_mm_res;
              r_state <= SQUARE;
            end else begin
              r_mm_b  <= DATA_W'(1);
              r_state <= FROMMONT;
            end
          end
        end
        FROMMONT: begin
          if (w_mm_done) begin
            r_result <= w_mm_res;
            r_done   <= 1'b1;
            r_state  <= FINISH;
          end
        end
        FINISH: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_modexp_controller.sv
// Scoreboard bench for modexp_controller at a reduced 64-bit width.
// Stimulus queues expected results; a negedge monitor checks each done.
module tb_modexp_controller;
  import modexp_controller_pkg::*;

  localparam int DW = 64;
  localparam int EW = 64;
  localparam int TW = $clog2(EW) + 1;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          start = 1'b0;
  logic [DW-1:0] in_x = '0;
  logic [EW-1:0] in_e = '0;
  logic [TW-1:0] in_t = '0;
  logic [DW-1:0] in_m = '0;
  logic [DW-1:0] in_r = '0;
  logic [DW-1:0] in_r2 = '0;
  logic [DW-1:0] result;
  logic          done;
  logic          busy;

  int n_checks = 0;
  int n_fail   = 0;
  int n_done   = 0;
  int mm_cnt   = 0;
  logic [DW-1:0] exp_q[$];

  modexp_controller #(
    .DATA_W(DW),
    .EXP_W (EW)
  ) dut (
    .clk   (clk),
    .resetn(resetn),
    .start (start),
    .in_x  (in_x),
    .in_e  (in_e),
    .in_t  (in_t),
    .in_m  (in_m),
    .in_r  (in_r),
    .in_r2 (in_r2),
    .result(result),
    .done  (done),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] mulmod(
    input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [DW-1:0] m);
    logic [2*DW-1:0] p;
    p = {{DW{1'b0}}, a} * {{DW{1'b0}}, b};
    p = p % {{DW{1'b0}}, m};
    return p[DW-1:0];
  endfunction

  function automatic logic [DW-1:0] rmod(input logic [DW-1:0] m);
    logic [2*DW-1:0] p;
    p = {{(DW-1){1'b0}}, 1'b1, {DW{1'b0}}};
    p = p % {{DW{1'b0}}, m};
    return p[DW-1:0];
  endfunction

  function automatic logic [DW-1:0] powmod(
    input logic [DW-1:0] x, input logic [EW-1:0] e, input int t,
    input logic [DW-1:0] m);
    logic [DW-1:0] a;
    a = mulmod(DW'(1), DW'(1), m);
    for (int i = t - 1; i >= 0; i--) begin
      a = mulmod(a, a, m);
      if (e[i]) a = mulmod(a, x, m);
    end
    return a;
  endfunction

  task automatic check(input string name, input logic [DW-1:0] act,
                       input logic [DW-1:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Monitor: count multiplier issues and score every done pulse.
  always @(negedge clk) begin
    if (dut.r_mm_start === 1'b1) mm_cnt++;
    if (done === 1'b1) begin
      n_done++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: result %0h with nothing queued", result);
      end else begin
        check("result", result, exp_q.pop_front());
      end
    end
  end

  task automatic issue(input logic [DW-1:0] x, input logic [EW-1:0] e,
                       input int t, input logic [DW-1:0] m);
    in_x  = x;
    in_e  = e;
    in_t  = TW'(t);
    in_m  = m;
    in_r  = rmod(m);
    in_r2 = mulmod(in_r, in_r, m);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run(input string name, input logic [DW-1:0] x,
                     input logic [EW-1:0] e, input int t,
                     input logic [DW-1:0] m, input logic [DW-1:0] req,
                     input int req_mm, input bit restart);
    int d0;
    bit got;
    exp_q.push_back(req);
    mm_cnt = 0;
    d0 = n_done;
    issue(x, e, t, m);
    if (restart) begin
      repeat (10) @(negedge clk);
      check({name, "_busy_mid"}, DW'(busy), DW'(1));
      issue(DW'(3), EW'(7), 3, DW'(11));
    end
    got = 1'b0;
    for (int c = 0; c < 20000 && !got; c++) begin
      @(negedge clk);
      if (done === 1'b1) got = 1'b1;
    end
    if (!got) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: no done, required done within 20000 cycles", name);
      exp_q.delete();
    end
    check({name, "_busy_finish"}, DW'(busy), DW'(1));
    repeat (3) @(negedge clk);
    check({name, "_done_pulses"}, DW'(n_done - d0), DW'(1));
    check({name, "_mm_starts"}, DW'(mm_cnt), DW'(req_mm));
    check({name, "_busy_idle"}, DW'(busy), DW'(0));
  endtask

  initial begin
    logic [DW-1:0] bx, bm, bexp;
    logic [EW-1:0] be;
    int d0;
    bit hit;

    repeat (3) @(negedge clk);
    check("rst_result", result, '0);
    check("rst_done", DW'(done), '0);
    check("rst_busy", DW'(busy), '0);
    resetn = 1'b1;
    @(negedge clk);

    run("basic", DW'(2), EW'('b1010), 4, DW'(1000003), DW'(1024), 8, 1'b0);
    run("t_zero", DW'(5), EW'('b1011), 0, DW'(7), DW'(1), 2, 1'b0);
    run("one_bit", DW'(5), EW'(1), 1, DW'(7), DW'(5), 4, 1'b0);
    run("t_trunc", DW'(3), '1, 3, DW'(1000003), DW'(2187), 8, 1'b0);
    run("x_zero", DW'(0), EW'(5), 3, DW'(1000003), DW'(0), 7, 1'b0);
    run("busy_start", DW'(2), EW'('b1010), 4, DW'(1000003), DW'(1024), 8, 1'b1);

    // Reset during SQUARE abandons the run.
    d0 = n_done;
    issue(DW'(2), EW'('b1010), 4, DW'(1000003));
    hit = 1'b0;
    for (int c = 0; c < 5000 && !hit; c++) begin
      @(negedge clk);
      if (dut.r_state == SQUARE) hit = 1'b1;
    end
    check("reach_square", DW'(hit), DW'(1));
    resetn = 1'b0;
    start  = 1'b1;
    @(negedge clk);
    check("midrst_busy", DW'(busy), '0);
    check("midrst_done", DW'(done), '0);
    check("midrst_result", result, '0);
    resetn = 1'b1;
    start  = 1'b0;
    repeat (200) @(negedge clk);
    check("midrst_no_done", DW'(n_done - d0), '0);
    check("rst_start_ignored", DW'(busy), '0);

    run("rerun", DW'(2), EW'('b1010), 4, DW'(1000003), DW'(1024), 8, 1'b0);

    bm   = 64'hF123_4567_89AB_CDEF;
    bx   = 64'h1234_5678_9ABC_DEF0;
    be   = 64'hDEAD_BEEF_0123_4567;
    bexp = powmod(bx, be, EW, bm);
    run("full", bx, be, EW, bm, bexp, 2 + EW + $countones(be), 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/modexp_controller.md
MODEXP_CONTROLLER -- requirements
Module: modexp_controller

Interface
REQ-001 SHALL have parameter DATA_W, default 512: operand, modulus and result width.
REQ-002 SHALL have parameter EXP_W, default 512: exponent register width.
REQ-003 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-004 SHALL have port resetn, input, 1: reset, synchronous and active-low.
REQ-005 SHALL have port start, input, 1: one-cycle request; operands sampled on the same edge.
REQ-006 SHALL have port in_x, input, DATA_W: base, with in_x < in_m.
REQ-007 SHALL have port in_e, input, EXP_W: exponent.
REQ-008 SHALL have port in_t, input, $clog2(EXP_W)+1: number of exponent bits used, in_e[in_t-1:0]; range 0..EXP_W.
REQ-009 SHALL have port in_m, input, DATA_W: odd modulus.
REQ-010 SHALL have port in_r, input, DATA_W: 2^DATA_W mod in_m.
REQ-011 SHALL have port in_r2, input, DATA_W: 2^(2*DATA_W) mod in_m.
REQ-012 SHALL have port result, output, DATA_W: in_x^e mod in_m.
REQ-013 SHALL have port done, output, 1: one-cycle pulse when result is valid.
REQ-014 SHALL have port busy, output, 1: high from the cycle after accepted start until done.

Function
REQ-015 SHALL register in_x, in_e, in_t, in_m, in_r and in_r2 when start=1 and busy=0; start while busy=1 SHALL be ignored.
REQ-016 SHALL compute left-to-right square-and-multiply with MM(a,b)=a*b*2^-DATA_W mod m:
- xt=MM(x,r2)
- A=r
- for i=t-1 downto 0: A=MM(A,A), and if e[i] then A=MM(A,xt)
- result=MM(A,1)
REQ-017 SHALL use FSM states IDLE, TOMONT, SQUARE, MULT, FROMMONT, FINISH.
REQ-018 Each compute state SHALL issue exactly one mm_start pulse on entry, then wait for mm_done; mm_a, mm_b and mm_m SHALL be registered and held stable until mm_done.
REQ-019 State transitions SHALL be:
- IDLE->TOMONT on accepted start.
- TOMONT->SQUARE if t>0, else ->FROMMONT.
- SQUARE->MULT if e[i]=1.
- SQUARE->SQUARE with i-1 if e[i]=0 and i>0.
- SQUARE->FROMMONT if e[i]=0 and i=0.
- MULT->SQUARE with i-1 if i>0, else ->FROMMONT.
- FROMMONT->FINISH.
- FINISH->IDLE.
REQ-020 Bit index i SHALL be a down-counter loaded with t-1; its decrement SHALL occur only on the mm_done that completes a step, never on wrap below 0.
REQ-021 In FINISH, done SHALL be 1 for exactly one cycle; result SHALL update on the same edge and hold until the next FINISH or reset.
REQ-022 t=0 SHALL yield result=1 mod m.
REQ-023 Total multiplier invocations SHALL be 2 + t + popcount(e[t-1:0]).
REQ-024 Latency from accepted start to done SHALL be the sum of multiplier latencies plus 2 cycles per invocation (issue, capture) plus 1 (FINISH).
REQ-025 busy SHALL be 0 in IDLE and 1 in all other states, including FINISH.

Reset
REQ-026 resetn=0 at a clock edge SHALL force state IDLE, result=0, done=0, busy=0, and mm_start=0, and clear all operand registers.
REQ-027 Reset mid-operation SHALL abandon the computation with no done pulse; the internal multiplier SHALL share resetn.
REQ-028 start during resetn=0 SHALL be ignored.

Structure
REQ-029 A shared package SHALL hold the FSM state enumeration and default DATA_W/EXP_W constants.
REQ-030 SHALL instantiate one existing montgomery sub-module (clk, resetn, start, in_a, in_b, in_m, result, done); no other sub-modules.

Verification
REQ-031 Basic exponent: x=2, e=4'b1010, t=4, m=1000003, r/r2 from vector generator -> result=1024, exactly one done pulse.
REQ-032 Zero-length exponent: x=5, t=0, m=7 -> result=1; mm_start count=2.
REQ-033 Single bit: x=5, e=1, t=1, m=7 -> result=5; mm_start count=4.
REQ-034 Start while busy: pulse start again mid-run in scenario REQ-031 -> ignored; mm_start count=8; result=1024.
REQ-035 Reset mid-operation: resetn=0 during SQUARE -> next cycle busy=0, done=0, result=0; rerun of REQ-031 -> result=1024.
REQ-036 Full-size vector: generator-produced 512-bit x, e, t=512, m -> result equals generator expected; error=0.
